// File: rtl/bitwise_logic_pipe.sv
// Two-stage pipelined bitwise logic unit (AND/OR/XOR/NOR) with optional B-bit broadcast,
// zero flag and valid/ready flow control.
module bitwise_logic_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             bcast,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero
);

    typedef enum logic [1:0] {
        OpAnd = 2'b00,
        OpOr  = 2'b01,
        OpXor = 2'b10,
        OpNor = 2'b11
    } op_e;

    logic             s1_load;
    logic             s2_load;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] res;

    logic             v1_q,   v1_d;
    logic [WIDTH-1:0] res1_q, res1_d;
    logic             v2_q,   v2_d;
    logic [WIDTH-1:0] y_q,    y_d;
    logic             zero_q, zero_d;

    // Each stage advances when it is empty or its downstream is moving.
    always_comb begin
        s2_load  = !v2_q || out_ready;
        s1_load  = !v1_q || s2_load;
        in_ready = s1_load;
    end

    always_comb begin
        b_eff = bcast ? {WIDTH{b[0]}} : b;
        res   = '0;
        unique case (op_e'(op))
            OpAnd: res = a & b_eff;
            OpOr:  res = a | b_eff;
            OpXor: res = a ^ b_eff;
            OpNor: res = ~(a | b_eff);
            default: res = '0;
        endcase
    end

    always_comb begin
        v1_d   = v1_q;
        res1_d = res1_q;
        if (s1_load) begin
            v1_d = in_valid;
            if (in_valid) begin
                res1_d = res;
            end
        end
    end

    always_comb begin
        v2_d   = v2_q;
        y_d    = y_q;
        zero_d = zero_q;
        if (s2_load) begin
            v2_d = v1_q;
            if (v1_q) begin
                y_d    = res1_q;
                zero_d = ~|res1_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            res1_q <= '0;
            v2_q   <= 1'b0;
            y_q    <= '0;
            zero_q <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            res1_q <= res1_d;
            v2_q   <= v2_d;
            y_q    <= y_d;
            zero_q <= zero_d;
        end
    end

    assign out_valid = v2_q;
    assign y         = y_q;
    assign zero      = zero_q;

endmodule
